core_pipe_exec_mdu: RTL and testbench
=====================================

Name: core_pipe_exec_mdu

Overview:
Iterative integer multiply/divide unit for the execute stage. It implements the RV M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) plus their word variants.
- Parametrised in XLEN, with a word mode.
- Multi-cycle, one bit per cycle.
- Valid/ready request and response handshakes, plus a pipeline flush.
- Sits beside the single-cycle integer ALU; the execute stage stalls while it is busy.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
WORD_OPS, 1, enable the word variants; must be 0 when XLEN=32.

Ports:
g_clk  in  1  core clock
g_resetn  in  1  synchronous active-low reset
flush  in  1  abandon any in-flight op
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
opr_a  in  XLEN  operand A (multiplicand/dividend)
opr_b  in  XLEN  operand B (multiplier/divisor)
word  in  1  operate on low 32 bits, sign-extend result
op_mul/op_mulh/op_mulhsu/op_mulhu  in  1 each  multiply selects, one-hot
op_div/op_divu/op_rem/op_remu  in  1 each  divide selects, one-hot
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  operation result
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock g_clk. Reset is synchronous, active-low on g_resetn. Reset forces IDLE, out_valid=0, result=0, busy=0 and clears the counter. in_ready=1 after reset.
- State machine:
  - IDLE: in_ready=1. On in_valid, capture operands, op and word, then go to BUSY. Special cases go straight to DONE instead.
  - BUSY: in_ready=0. Performs W iterations, where W=32 if word else XLEN. After the W-th iteration go to DONE.
  - DONE: out_valid=1; result and out_valid are held stable until out_ready. DONE with out_ready goes to IDLE. A new request is not accepted in that same cycle.
- Latency: request accepted at cycle N; out_valid first high at N+W+1. Special cases give out_valid at N+1.
- Operands and signedness:
  - Effective operands are the low W bits of each input.
  - Signed operands (mul/mulh/div/rem: both; mulhsu: A only) are converted to magnitudes at capture; the result sign is fixed up at the end.
- Multiply: shift-add producing a 2W-bit product.
  - MUL returns the low W bits.
  - MULH* returns the high W bits.
  - If exactly one operand was negative, the full 2W-bit product is negated before selecting.
- Divide: restoring division on magnitudes.
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Special cases (detected at capture, no iteration):
  - Divisor zero: quotient = all-ones; remainder = dividend.
  - Signed overflow, i.e. dividend = most-negative and divisor = -1: quotient = dividend; remainder = 0.
- Word mode: the low 32-bit result is sign-extended to XLEN. This applies to unsigned ops too.
- Flush:
  - Has priority over everything; the next state is IDLE from any state.
  - out_valid is 0 in the cycle after flush.
  - A request in the same cycle as flush is dropped.
- Operand timing: operands and op selects are only sampled on acceptance. Later changes to them have no effect.
- Request with no op select set: complete in one cycle with result=0.
- Counter: 6-bit iteration counter counting down from W-1. It saturates and never wraps.

Decomposition:
- Shared package core_mdu_pkg holds:
  - enum mdu_state_t {IDLE, BUSY, DONE}.
  - Op-encoding typedef and the constants for W.
- One sub-module, core_pipe_exec_mdu_div: iterative restoring divider core with start/done, reused for the remainder path.
- Multiply and sign fix-up stay in the top.

Test Plan:
- XLEN=64, op_mul, A=7, B=-3 -> out_valid at N+65, result=0xFFFF_FFFF_FFFF_FFEB.
- op_mulhu, A=B=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE; op_mulhsu, A=-1, B=2 -> result=0xFFFF_FFFF_FFFF_FFFF.
- op_div/op_rem, A=-7, B=2 -> quotient -3, remainder -1. With B=0: out_valid at N+1, div result all-ones, rem result -7.
- word op_div, A=0x8000_0000, B=-1 -> out_valid at N+1, result=0xFFFF_FFFF_8000_0000. Word op_divu, A=0x1_0000_0010, B=4 -> out_valid at N+33, result=4.
- Backpressure: out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
- Flush at BUSY iteration 10, and separately g_resetn=0 mid-op -> IDLE next cycle, out_valid=0. A following request for 6 DIVU 3 -> result 2.

Source files
------------

// File: rtl/core_mdu_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
//   mdu_state_t : sequencer states (IDLE, BUSY, DONE)
//   mdu_op_t    : compact encoding of the one-hot op selects
//   mdu_ctl_t   : per-request control captured at acceptance
//   WORD_W/CNT_W: word-mode width and iteration counter width
package core_mdu_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

  typedef enum logic [3:0] {
    OP_NONE, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } mdu_op_t;

  typedef struct packed {
    mdu_op_t op;
    logic    word;
    logic    neg_a;  // operand A was negative (and treated as signed)
    logic    neg_b;  // operand B was negative (and treated as signed)
  } mdu_ctl_t;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 6;

  function automatic logic op_is_div(mdu_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_a_signed(mdu_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(mdu_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/core_pipe_exec_mdu_div.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per
// step. The caller pre-aligns the dividend so its active MSB sits at bit
// XLEN-1; after W steps the quotient occupies the low W bits of quotient.
//   g_clk, g_resetn : clock, synchronous active-low reset
//   start           : load dividend/divisor, clear the partial remainder
//   step            : perform one restoring iteration
//   last            : the current step is the final one
//   dividend/divisor: magnitudes, sampled on start
//   quotient/remainder : running (final after the last step)
//   done            : high during the final step
module core_pipe_exec_mdu_div #(
  parameter int XLEN = 64
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            start,
  input  logic            step,
  input  logic            last,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  logic [XLEN-1:0] dvsr, quo, rem;
  logic [XLEN:0]   trial;
  logic            fits;

  // Bring the next dividend bit into the partial remainder and try the subtract.
  assign trial = {rem, quo[XLEN-1]};
  assign fits  = trial >= {1'b0, dvsr};

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      dvsr <= '0;
      quo  <= '0;
      rem  <= '0;
    end else if (start) begin
      dvsr <= divisor;
      quo  <= dividend;
      rem  <= '0;
    end else if (step) begin
      // When the subtract fits the difference is below dvsr, so XLEN bits hold it.
      rem <= fits ? XLEN'(trial - {1'b0, dvsr}) : trial[XLEN-1:0];
      quo <= {quo[XLEN-2:0], fits};
    end
  end

  assign quotient  = quo;
  assign remainder = rem;
  assign done      = step & last;

endmodule

// File: rtl/core_pipe_exec_mdu.sv
// Execute-stage iterative multiply/divide unit (RV M-extension incl. word ops).
// Operands are reduced to magnitudes at acceptance, a shift-add multiplier or
// the restoring divider runs one bit per cycle, and the sign is fixed up on
// the way out. Divide-by-zero, signed overflow and empty op selects finish
// without iterating.
//   g_clk, g_resetn : clock, synchronous active-low reset
//   flush           : abandon any in-flight op (wins over everything)
//   in_valid/in_ready   : request handshake; opr_a, opr_b, word, op_* sampled on accept
//   out_valid/out_ready : response handshake; result held while out_valid
//   busy            : unit not idle
module core_pipe_exec_mdu
  import core_mdu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit WORD_OPS = 1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] opr_a,
  input  logic [XLEN-1:0] opr_b,
  input  logic            word,
  input  logic            op_mul,
  input  logic            op_mulh,
  input  logic            op_mulhsu,
  input  logic            op_mulhu,
  input  logic            op_div,
  input  logic            op_divu,
  input  logic            op_rem,
  input  logic            op_remu,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam bit          WORD_EN = WORD_OPS && (XLEN > 32);
  localparam int unsigned WSH     = XLEN - WORD_W;  // alignment shift in word mode

  mdu_state_t      state, state_n;
  mdu_ctl_t        ctl, ctl_in;
  mdu_op_t         op_in;
  logic [CNT_W-1:0] cnt;
  logic            accept, word_in, neg_a_in, neg_b_in, div_zero, ovf, spec_in, spec_q;
  logic [XLEN-1:0] w_mask, a_w, b_w, a_mag, b_mag, min_neg, spec_val, spec_res;
  logic [XLEN-1:0] mcand, hi, lo;
  logic [XLEN:0]   mul_sum;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo, rem, q_s, r_s, raw;
  logic            div_step, div_done, mul_step, last_step;

  // ---------------- capture-side decode ----------------
  always_comb begin
    op_in = OP_NONE;
    if      (op_mul)    op_in = OP_MUL;
    else if (op_mulh)   op_in = OP_MULH;
    else if (op_mulhsu) op_in = OP_MULHSU;
    else if (op_mulhu)  op_in = OP_MULHU;
    else if (op_div)    op_in = OP_DIV;
    else if (op_divu)   op_in = OP_DIVU;
    else if (op_rem)    op_in = OP_REM;
    else if (op_remu)   op_in = OP_REMU;
  end

  assign word_in  = WORD_EN && word;
  assign w_mask   = word_in ? XLEN'({WORD_W{1'b1}}) : '1;
  assign a_w      = opr_a & w_mask;
  assign b_w      = opr_b & w_mask;
  assign neg_a_in = op_a_signed(op_in) && (word_in ? opr_a[WORD_W-1] : opr_a[XLEN-1]);
  assign neg_b_in = op_b_signed(op_in) && (word_in ? opr_b[WORD_W-1] : opr_b[XLEN-1]);
  // Negating the zero-extended value then masking gives the W-bit magnitude.
  assign a_mag    = (neg_a_in ? -a_w : a_w) & w_mask;
  assign b_mag    = (neg_b_in ? -b_w : b_w) & w_mask;
  assign min_neg  = word_in ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};

  assign div_zero = op_is_div(op_in) && (b_w == '0);
  assign ovf      = (op_in == OP_DIV || op_in == OP_REM) && (a_w == min_neg) && (b_w == w_mask);
  assign spec_in  = (op_in == OP_NONE) || div_zero || ovf;

  always_comb begin
    spec_val = '0;
    if (div_zero)  spec_val = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : a_w;
    else if (ovf)  spec_val = (op_in == OP_DIV) ? a_w : '0;
  end

  assign ctl_in = '{op: op_in, word: word_in, neg_a: neg_a_in, neg_b: neg_b_in};

  // ---------------- sequencer ----------------
  assign accept    = (state == IDLE) && in_valid && !flush;
  assign mul_step  = (state == BUSY) && !op_is_div(ctl.op);
  assign div_step  = (state == BUSY) && op_is_div(ctl.op);
  assign last_step = op_is_div(ctl.op) ? div_done : (cnt == '0);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = spec_in ? DONE : BUSY;
      BUSY:    if (last_step) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state    <= IDLE;
      ctl      <= '0;
      cnt      <= '0;
      spec_q   <= 1'b0;
      spec_res <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        ctl      <= ctl_in;
        cnt      <= word_in ? CNT_W'(WORD_W-1) : CNT_W'(XLEN-1);
        spec_q   <= spec_in;
        spec_res <= spec_val;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // ---------------- shift-add multiplier ----------------
  // {hi,lo} shifts right each step; lo starts as the multiplier and is
  // consumed from its LSB while product bits fill in from the top.
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (accept) begin
      mcand <= a_mag;
      hi    <= '0;
      lo    <= b_mag;
    end else if (mul_step) begin
      hi <= mul_sum[XLEN:1];
      lo <= {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // After only W steps in word mode the product sits WSH bits too high.
  assign prod   = ctl.word ? ({hi, lo} >> WSH) : {hi, lo};
  assign prod_s = (ctl.neg_a ^ ctl.neg_b) ? -prod : prod;

  // ---------------- divider ----------------
  core_pipe_exec_mdu_div #(.XLEN(XLEN)) u_div (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .start     (accept),
    .step      (div_step),
    .last      (cnt == '0),
    .dividend  (word_in ? (a_mag << WSH) : a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem),
    .done      (div_done)
  );

  assign q_s = (ctl.neg_a ^ ctl.neg_b) ? -quo : quo;
  assign r_s = ctl.neg_a ? -rem : rem;  // remainder follows the dividend's sign

  // ---------------- result ----------------
  always_comb begin
    raw = '0;
    case (ctl.op)
      OP_MUL:                       raw = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: raw = ctl.word ? XLEN'(prod_s[2*WORD_W-1:WORD_W])
                                                   : prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              raw = q_s;
      OP_REM, OP_REMU:              raw = r_s;
      default:                      raw = '0;
    endcase
    if (spec_q) raw = spec_res;
  end

  assign out_valid = (state == DONE);
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  // Word results are sign-extended from bit 31, unsigned ops included.
  assign result    = !out_valid ? '0 :
                     ctl.word   ? XLEN'($signed(raw[WORD_W-1:0])) : raw;

endmodule

// File: tb/tb_core_pipe_exec_mdu.sv
// Directed bench for core_pipe_exec_mdu (XLEN=64, word ops enabled).
module tb_core_pipe_exec_mdu;

  localparam logic [7:0] MUL = 8'h80, MULH = 8'h40, MULHSU = 8'h20, MULHU = 8'h10;
  localparam logic [7:0] DIV = 8'h08, DIVU = 8'h04, REM = 8'h02, REMU = 8'h01, NOP = 8'h00;

  logic        g_clk = 1'b0;
  logic        g_resetn, flush, in_valid, in_ready, word, out_valid, out_ready, busy;
  logic        op_mul, op_mulh, op_mulhsu, op_mulhu, op_div, op_divu, op_rem, op_remu;
  logic [63:0] opr_a, opr_b, result;
  int          checks = 0;
  int          failures = 0;

  core_pipe_exec_mdu #(.XLEN(64), .WORD_OPS(1)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opr_a(opr_a), .opr_b(opr_b), .word(word),
    .op_mul(op_mul), .op_mulh(op_mulh), .op_mulhsu(op_mulhsu), .op_mulhu(op_mulhu),
    .op_div(op_div), .op_divu(op_divu), .op_rem(op_rem), .op_remu(op_remu),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 g_clk = ~g_clk;

  task automatic set_ops(input logic [7:0] ops);
    {op_mul, op_mulh, op_mulhsu, op_mulhu, op_div, op_divu, op_rem, op_remu} = ops;
  endtask

  // Issue one request from IDLE, scramble the inputs after acceptance, and
  // report latency (edges from accept, inclusive) and the result; lat=-1 on timeout.
  task automatic run_op(input logic [7:0] ops, input logic [63:0] a, input logic [63:0] b,
                        input logic w, input logic rdy, output logic [63:0] res, output int lat);
    set_ops(ops); opr_a = a; opr_b = b; word = w; out_ready = rdy; in_valid = 1'b1;
    @(posedge g_clk); #1;
    in_valid = 1'b0; opr_a = {$urandom, $urandom}; opr_b = {$urandom, $urandom};
    word = ~w; set_ops(MULHSU);
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge g_clk); #1; lat++; end
    if (!out_valid) lat = -1;
    res = result;
    if (rdy) begin @(posedge g_clk); #1; end
  endtask

  task automatic test_reset();
    g_resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; word = 1'b0;
    opr_a = '0; opr_b = '0; set_ops(NOP);
    repeat (3) @(posedge g_clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (result !== 64'h0) begin failures++; $display("FAIL reset_result got %h exp 0", result); end
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
  endtask

  // Table-driven op vectors: latency and result per row.
  task automatic test_ops();
    localparam int N = 19;
    logic [7:0]  ops [N];
    logic [63:0] a [N], b [N], e [N];
    logic        w [N];
    int          el [N];
    logic [63:0] r;
    int          l;
    ops = '{MUL, MULHU, MULHSU, MUL, MULH,
            DIV, REM, DIV, REM, DIVU, REMU, DIV, REM,
            DIV, DIVU, DIVU, REMU, NOP, MULH};
    a   = '{64'd7, '1, '1, 64'hFFFF_FFFF, 64'h8000_0000_0000_0000,
            -64'sd7, -64'sd7, -64'sd7, -64'sd7, 64'd100, 64'd100,
            64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
            64'h8000_0000, 64'h1_0000_0010, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd5, '1};
    b   = '{-64'sd3, '1, 64'd2, 64'd2, 64'h8000_0000_0000_0000,
            64'd2, 64'd2, 64'd0, 64'd0, 64'd7, 64'd7, '1, '1,
            '1, 64'd4, 64'd1, 64'h10, 64'd9, '1};
    w   = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0};
    e   = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFE, '1, 64'hFFFF_FFFF_FFFF_FFFE,
            64'h4000_0000_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFD, '1, '1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 64'd2,
            64'h8000_0000_0000_0000, 64'd0,
            64'hFFFF_FFFF_8000_0000, 64'd4, '1, 64'd15, 64'd0, 64'd0};
    el  = '{65, 65, 65, 33, 65,  65, 65, 1, 1, 65, 65, 1, 1,  1, 33, 33, 33, 1, 65};
    for (int i = 0; i < N; i++) begin
      run_op(ops[i], a[i], b[i], w[i], 1'b1, r, l);
      checks++; if (l !== el[i]) begin failures++; $display("FAIL op%0d_latency got %0d exp %0d", i, l, el[i]); end
      checks++; if (r !== e[i]) begin failures++; $display("FAIL op%0d_result got %h exp %h", i, r, e[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] r;
    int          l;
    run_op(DIVU, 64'd6, 64'd3, 1'b0, 1'b0, r, l);
    checks++; if (r !== 64'd2) begin failures++; $display("FAIL bp_result got %h exp 2", r); end
    for (int i = 0; i < 5; i++) begin
      @(posedge g_clk); #1;
      checks++; if (result !== 64'd2 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d got res=%h ov=%b ir=%b exp res=2 ov=1 ir=0", i, result, out_valid, in_ready);
      end
    end
    // A request offered during the releasing DONE cycle must not be taken.
    out_ready = 1'b1; in_valid = 1'b1; set_ops(MUL); opr_a = 64'd3; opr_b = 64'd3;
    @(posedge g_clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_release got ir=%b ov=%b busy=%b exp 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_flush();
    logic [63:0] r;
    int          l;
    set_ops(DIVU); opr_a = 64'd1000; opr_b = 64'd3; word = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge g_clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge g_clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_pre_busy got %b exp 1", busy); end
    flush = 1'b1; in_valid = 1'b1; set_ops(MUL);
    @(posedge g_clk); #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_busy got busy=%b ov=%b ir=%b exp 0 0 1", busy, out_valid, in_ready);
    end
    // Still flushing with a request pending from IDLE: dropped.
    @(posedge g_clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_drop got busy=%b exp 0", busy); end
    run_op(DIVU, 64'd6, 64'd3, 1'b0, 1'b1, r, l);
    checks++; if (r !== 64'd2 || l !== 65) begin failures++; $display("FAIL flush_after got res=%h lat=%0d exp 2 65", r, l); end
  endtask

  task automatic test_reset_midop();
    logic [63:0] r;
    int          l;
    set_ops(MUL); opr_a = 64'd12345; opr_b = 64'd678; word = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge g_clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge g_clk); #1;
    g_resetn = 1'b0;
    @(posedge g_clk); #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 64'd0) begin
      failures++; $display("FAIL rst_mid got busy=%b ov=%b ir=%b res=%h exp 0 0 1 0", busy, out_valid, in_ready, result);
    end
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    run_op(DIVU, 64'd6, 64'd3, 1'b0, 1'b1, r, l);
    checks++; if (r !== 64'd2 || l !== 65) begin failures++; $display("FAIL rst_after got res=%h lat=%0d exp 2 65", r, l); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r;
    int          l;
    run_op(REMU, 64'd100, 64'd7, 1'b0, 1'b1, r, l);
    checks++; if (r !== 64'd2) begin failures++; $display("FAIL b2b_remu got %h exp 2", r); end
    run_op(MULH, '1, '1, 1'b0, 1'b1, r, l);
    checks++; if (r !== 64'd0) begin failures++; $display("FAIL b2b_mulh got %h exp 0", r); end
    run_op(MUL, 64'd7, -64'sd3, 1'b0, 1'b1, r, l);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("FAIL b2b_mul got %h exp fff...feb", r); end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
